reg_bank_arb: RTL and testbench

Parametrised dual-master register bank sitting between the SPI slave and the instruction decoder. It provides byte-strobed writes and two independent write ports that may both commit in one cycle. Same-address collisions are arbitrated with a valid/ready handshake. Per-register read-only and write-1-to-clear modes apply to the SPI side, along with hardware-set status bits and registered read ports with a valid flag.

---
 rtl/reg_bank_pkg.sv | 39 +++
 rtl/reg_bank_wr_arb.sv | 60 ++++++
 rtl/reg_bank_arb.sv | 140 ++++++++++++++
 tb/tb_reg_bank_arb.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared types, arbitration mode constants and byte-lane merge helpers
// for the dual-master register bank.
package reg_bank_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    typedef enum logic {
        GRANT_SPI = 1'b0,
        GRANT_DEC = 1'b1
    } grant_e;

    // Plain byte write: an enabled lane takes the new byte, a disabled lane keeps the old one.
    function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                              input logic [7:0] new_b,
                                              input logic       strb_b);
        logic [7:0] res;
        if (strb_b) begin
            res = new_b;
        end else begin
            res = old_b;
        end
        return res;
    endfunction

    // Write-1-to-clear byte: in an enabled lane every 1 in new_b clears that bit.
    function automatic logic [7:0] w1c_merge(input logic [7:0] old_b,
                                             input logic [7:0] new_b,
                                             input logic       strb_b);
        logic [7:0] res;
        if (strb_b) begin
            res = old_b & ~new_b;
        end else begin
            res = old_b;
        end
        return res;
    endfunction

endpackage

// File: rtl/reg_bank_wr_arb.sv
// Write-port arbiter: detects same-address conflicts between the SPI and
// decoder write ports, generates the ready handshakes, keeps the
// round-robin pointer and registers the collision pulse.
module reg_bank_wr_arb
    import reg_bank_pkg::*;
#(
    parameter int AW       = 4,
    parameter int ARB_MODE = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          spi_wr_en,
    input  logic          dec_wr_en,
    input  logic [AW-1:0] spi_addr_wr,
    input  logic [AW-1:0] dec_addr_wr,
    output logic          spi_wr_ready,
    output logic          dec_wr_ready,
    output logic          wr_collision
);

    logic   conflict_s;
    grant_e winner_s;
    grant_e rr_ptr_r;   // port favoured in the next conflict

    // Conflict detection, winner selection and ready generation.
    always_comb begin
        conflict_s   = spi_wr_en && dec_wr_en && (spi_addr_wr == dec_addr_wr);
        winner_s     = GRANT_SPI;
        spi_wr_ready = 1'b1;
        dec_wr_ready = 1'b1;
        if (ARB_MODE == ARB_RR) begin
            winner_s = rr_ptr_r;
        end else begin
            winner_s = GRANT_SPI;
        end
        if (conflict_s) begin
            spi_wr_ready = (winner_s == GRANT_SPI);
            dec_wr_ready = (winner_s == GRANT_DEC);
        end else begin
            spi_wr_ready = 1'b1;
            dec_wr_ready = 1'b1;
        end
    end

    // Round-robin pointer flips to the loser after each conflict; collision pulse one cycle later.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr_r     <= GRANT_SPI;
            wr_collision <= 1'b0;
        end else begin
            wr_collision <= conflict_s;
            if (conflict_s) begin
                rr_ptr_r <= (winner_s == GRANT_SPI) ? GRANT_DEC : GRANT_SPI;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

endmodule

// File: rtl/reg_bank_arb.sv
// Dual-master register bank: byte-strobed SPI and decoder write ports,
// per-register read-only / write-1-to-clear behaviour on the SPI side,
// hardware status set, registered read ports and combinational taps.
module reg_bank_arb
    import reg_bank_pkg::*;
#(
    parameter int                DATA_WIDTH = 32,
    parameter int                NUM_REGS   = 16,
    parameter int                ARB_MODE   = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0,
    parameter logic [NUM_REGS-1:0] W1C_MASK = '0,
    localparam int               AW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    localparam int               SW         = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  spi_wr_en,
    input  logic                  dec_wr_en,
    output logic                  spi_wr_ready,
    output logic                  dec_wr_ready,
    input  logic [AW-1:0]         spi_addr_wr,
    input  logic [AW-1:0]         dec_addr_wr,
    input  logic [DATA_WIDTH-1:0] data_wr_spi,
    input  logic [DATA_WIDTH-1:0] data_wr_dec,
    input  logic [SW-1:0]         spi_wr_strb,
    input  logic [SW-1:0]         dec_wr_strb,
    input  logic                  spi_rd_en,
    input  logic [AW-1:0]         spi_addr_rd,
    input  logic [AW-1:0]         dec_addr_rd,
    output logic [DATA_WIDTH-1:0] data_rd_spi,
    output logic [DATA_WIDTH-1:0] data_rd_dec,
    output logic                  spi_rd_valid,
    input  logic [AW-1:0]         ctrl_reg_addr,
    input  logic [AW-1:0]         stat_reg_addr,
    output logic [DATA_WIDTH-1:0] ctrl_out,
    output logic [DATA_WIDTH-1:0] stat_out,
    input  logic [DATA_WIDTH-1:0] stat_hw_set,
    output logic                  wr_collision
);

    logic [DATA_WIDTH-1:0] regs_r     [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_nxt_s [NUM_REGS];
    logic [NUM_REGS-1:0]   spi_hit_s;
    logic [NUM_REGS-1:0]   dec_hit_s;
    logic [NUM_REGS-1:0]   stat_hit_s;
    logic [DATA_WIDTH-1:0] rd_spi_s;
    logic [DATA_WIDTH-1:0] rd_dec_s;

    reg_bank_wr_arb #(
        .AW       (AW),
        .ARB_MODE (ARB_MODE)
    ) u_wr_arb (
        .clk          (clk),
        .reset_n      (reset_n),
        .spi_wr_en    (spi_wr_en),
        .dec_wr_en    (dec_wr_en),
        .spi_addr_wr  (spi_addr_wr),
        .dec_addr_wr  (dec_addr_wr),
        .spi_wr_ready (spi_wr_ready),
        .dec_wr_ready (dec_wr_ready),
        .wr_collision (wr_collision)
    );

    // Per-register hit vectors; out-of-range addresses match nothing, so such writes vanish.
    always_comb begin
        spi_hit_s  = '0;
        dec_hit_s  = '0;
        stat_hit_s = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            spi_hit_s[i]  = spi_wr_en && spi_wr_ready && (spi_addr_wr == AW'(i)) && !RO_MASK[i];
            dec_hit_s[i]  = dec_wr_en && dec_wr_ready && (dec_addr_wr == AW'(i));
            stat_hit_s[i] = (stat_reg_addr == AW'(i));
        end
    end

    // Next register contents: write merge first, then hardware set wins over clears and writes.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_nxt_s[i] = regs_r[i];
            for (int b = 0; b < SW; b++) begin
                if (spi_hit_s[i]) begin
                    regs_nxt_s[i][8*b +: 8] = W1C_MASK[i]
                        ? w1c_merge(regs_r[i][8*b +: 8], data_wr_spi[8*b +: 8], spi_wr_strb[b])
                        : byte_merge(regs_r[i][8*b +: 8], data_wr_spi[8*b +: 8], spi_wr_strb[b]);
                end else if (dec_hit_s[i]) begin
                    regs_nxt_s[i][8*b +: 8] =
                        byte_merge(regs_r[i][8*b +: 8], data_wr_dec[8*b +: 8], dec_wr_strb[b]);
                end else begin
                    regs_nxt_s[i][8*b +: 8] = regs_r[i][8*b +: 8];
                end
            end
            regs_nxt_s[i] = regs_nxt_s[i] | (stat_hit_s[i] ? stat_hw_set : {DATA_WIDTH{1'b0}});
        end
    end

    // Storage array.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= regs_nxt_s[i];
            end
        end
    end

    // Read and tap multiplexers; unmatched (out-of-range) addresses yield zero.
    always_comb begin
        rd_spi_s = '0;
        rd_dec_s = '0;
        ctrl_out = '0;
        stat_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_spi_s = rd_spi_s | ({DATA_WIDTH{spi_addr_rd   == AW'(i)}} & regs_r[i]);
            rd_dec_s = rd_dec_s | ({DATA_WIDTH{dec_addr_rd   == AW'(i)}} & regs_r[i]);
            ctrl_out = ctrl_out | ({DATA_WIDTH{ctrl_reg_addr == AW'(i)}} & regs_r[i]);
            stat_out = stat_out | ({DATA_WIDTH{stat_reg_addr == AW'(i)}} & regs_r[i]);
        end
    end

    // Registered read ports: decoder follows every cycle, SPI loads only on request.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_rd_spi  <= '0;
            data_rd_dec  <= '0;
            spi_rd_valid <= 1'b0;
        end else begin
            data_rd_dec  <= rd_dec_s;
            spi_rd_valid <= spi_rd_en;
            if (spi_rd_en) begin
                data_rd_spi <= rd_spi_s;
            end else begin
                data_rd_spi <= data_rd_spi;
            end
        end
    end

endmodule

// File: tb/tb_reg_bank_arb.sv
// Self-checking bench for reg_bank_arb (round-robin mode, reg 6 W1C, reg 7 RO).
module tb_reg_bank_arb;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          spi_wr_en, dec_wr_en;
    logic          spi_wr_ready, dec_wr_ready;
    logic [AW-1:0] spi_addr_wr, dec_addr_wr;
    logic [DW-1:0] data_wr_spi, data_wr_dec;
    logic [SW-1:0] spi_wr_strb, dec_wr_strb;
    logic          spi_rd_en;
    logic [AW-1:0] spi_addr_rd, dec_addr_rd;
    logic [DW-1:0] data_rd_spi, data_rd_dec;
    logic          spi_rd_valid;
    logic [AW-1:0] ctrl_reg_addr, stat_reg_addr;
    logic [DW-1:0] ctrl_out, stat_out;
    logic [DW-1:0] stat_hw_set;
    logic          wr_collision;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] exp_v;
    logic          model_fav_dec;

    always #5 clk = ~clk;

    reg_bank_arb #(
        .DATA_WIDTH (32),
        .NUM_REGS   (16),
        .ARB_MODE   (1),
        .RO_MASK    (16'h0080),
        .W1C_MASK   (16'h0040)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .spi_wr_en     (spi_wr_en),
        .dec_wr_en     (dec_wr_en),
        .spi_wr_ready  (spi_wr_ready),
        .dec_wr_ready  (dec_wr_ready),
        .spi_addr_wr   (spi_addr_wr),
        .dec_addr_wr   (dec_addr_wr),
        .data_wr_spi   (data_wr_spi),
        .data_wr_dec   (data_wr_dec),
        .spi_wr_strb   (spi_wr_strb),
        .dec_wr_strb   (dec_wr_strb),
        .spi_rd_en     (spi_rd_en),
        .spi_addr_rd   (spi_addr_rd),
        .dec_addr_rd   (dec_addr_rd),
        .data_rd_spi   (data_rd_spi),
        .data_rd_dec   (data_rd_dec),
        .spi_rd_valid  (spi_rd_valid),
        .ctrl_reg_addr (ctrl_reg_addr),
        .stat_reg_addr (stat_reg_addr),
        .ctrl_out      (ctrl_out),
        .stat_out      (stat_out),
        .stat_hw_set   (stat_hw_set),
        .wr_collision  (wr_collision)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        spi_wr_en     = 1'b0;
        dec_wr_en     = 1'b0;
        spi_addr_wr   = 4'd0;
        dec_addr_wr   = 4'd0;
        data_wr_spi   = 32'h0;
        data_wr_dec   = 32'h0;
        spi_wr_strb   = 4'h0;
        dec_wr_strb   = 4'h0;
        spi_rd_en     = 1'b0;
        spi_addr_rd   = 4'd0;
        dec_addr_rd   = 4'd0;
        ctrl_reg_addr = 4'd0;
        stat_reg_addr = 4'd0;
        stat_hw_set   = 32'h0;
    endtask

    task automatic spi_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        spi_wr_en = 1'b1; spi_addr_wr = a; data_wr_spi = d; spi_wr_strb = s;
    endtask

    task automatic dec_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        dec_wr_en = 1'b1; dec_addr_wr = a; data_wr_dec = d; dec_wr_strb = s;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        step();
        step();
        n_tests++;
        if ({spi_rd_valid, wr_collision} !== 2'b00) begin
            n_fail++; $display("FAIL reset_flags got %b want 00", {spi_rd_valid, wr_collision});
        end
        reset_n = 1'b1;
        for (int a = 0; a < 16; a++) begin
            spi_rd_en = 1'b1; spi_addr_rd = a[3:0]; ctrl_reg_addr = a[3:0];
            exp_q.push_back(32'h0);
            #1;
            n_tests++;
            if (ctrl_out !== 32'h0) begin
                n_fail++; $display("FAIL reset_tap[%0d] got %h want 0", a, ctrl_out);
            end
            step();
            exp_v = exp_q.pop_front();
            n_tests++;
            if (data_rd_spi !== exp_v || spi_rd_valid !== 1'b1) begin
                n_fail++; $display("FAIL reset_read[%0d] got %h/%b want %h/1", a, data_rd_spi, spi_rd_valid, exp_v);
            end
        end
        spi_rd_en = 1'b0;
        step();
        n_tests++;
        if (spi_rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL rd_valid_drop got %b want 0", spi_rd_valid);
        end
    endtask

    task automatic test_dual_write();
        spi_wr(4'd2, 32'hAABBCCDD, 4'hF);
        dec_wr(4'd5, 32'h11223344, 4'hF);
        #1;
        n_tests++;
        if ({spi_wr_ready, dec_wr_ready} !== 2'b11) begin
            n_fail++; $display("FAIL dual_ready got %b want 11", {spi_wr_ready, dec_wr_ready});
        end
        step();
        spi_wr_en = 1'b0; dec_wr_en = 1'b0;
        ctrl_reg_addr = 4'd2; stat_reg_addr = 4'd5;
        #1;
        n_tests++;
        if (ctrl_out !== 32'hAABBCCDD || stat_out !== 32'h11223344) begin
            n_fail++; $display("FAIL dual_taps got %h/%h want aabbccdd/11223344", ctrl_out, stat_out);
        end
        spi_rd_en = 1'b1; spi_addr_rd = 4'd5; dec_addr_rd = 4'd2;
        exp_q.push_back(32'h11223344);
        step();
        spi_rd_en = 1'b0;
        exp_v = exp_q.pop_front();
        n_tests++;
        if (data_rd_spi !== exp_v || data_rd_dec !== 32'hAABBCCDD) begin
            n_fail++; $display("FAIL dual_read got %h/%h want %h/aabbccdd", data_rd_spi, data_rd_dec, exp_v);
        end
    endtask

    task automatic test_collision();
        logic          spi_win;
        logic [DW-1:0] sd, dd;
        model_fav_dec = 1'b0;
        ctrl_reg_addr = 4'd3;
        for (int k = 0; k < 3; k++) begin
            sd = 32'h1000_0000 + k;
            dd = 32'h2000_0000 + k;
            spi_wr(4'd3, sd, 4'hF);
            dec_wr(4'd3, dd, 4'hF);
            spi_win = !model_fav_dec;
            #1;
            n_tests++;
            if ({spi_wr_ready, dec_wr_ready} !== {spi_win, !spi_win}) begin
                n_fail++; $display("FAIL coll_grant[%0d] got %b want %b", k, {spi_wr_ready, dec_wr_ready}, {spi_win, !spi_win});
            end
            step();
            model_fav_dec = spi_win;
            if (spi_win) spi_wr_en = 1'b0; else dec_wr_en = 1'b0;
            #1;
            n_tests++;
            if (ctrl_out !== (spi_win ? sd : dd) || wr_collision !== 1'b1) begin
                n_fail++; $display("FAIL coll_winner[%0d] got %h/%b want %h/1", k, ctrl_out, wr_collision, spi_win ? sd : dd);
            end
            step();
            spi_wr_en = 1'b0; dec_wr_en = 1'b0;
            #1;
            n_tests++;
            if (ctrl_out !== (spi_win ? dd : sd) || wr_collision !== 1'b0) begin
                n_fail++; $display("FAIL coll_loser[%0d] got %h/%b want %h/0", k, ctrl_out, wr_collision, spi_win ? dd : sd);
            end
        end
    endtask

    task automatic test_strobe();
        dec_wr(4'd4, 32'hFFFFFFFF, 4'hF);
        step();
        dec_wr_en = 1'b0;
        spi_wr(4'd4, 32'h0, 4'b0101);
        step();
        spi_wr_en = 1'b0;
        ctrl_reg_addr = 4'd4;
        spi_rd_en = 1'b1; spi_addr_rd = 4'd4;
        exp_q.push_back(32'hFF00FF00);
        #1;
        n_tests++;
        if (ctrl_out !== 32'hFF00FF00) begin
            n_fail++; $display("FAIL strobe_tap got %h want ff00ff00", ctrl_out);
        end
        step();
        spi_rd_en = 1'b0;
        exp_v = exp_q.pop_front();
        n_tests++;
        if (data_rd_spi !== exp_v) begin
            n_fail++; $display("FAIL strobe_read got %h want %h", data_rd_spi, exp_v);
        end
    endtask

    task automatic test_modes();
        logic [DW-1:0] sdat [4];
        logic [DW-1:0] hset [4];
        logic [DW-1:0] want [4];
        sdat = '{32'h0000000F, 32'h0000F001, 32'h00000001, 32'h00000001};
        hset = '{32'h0,        32'h1,        32'h1,        32'h0};
        want = '{32'h0000F000, 32'h00000001, 32'h00000001, 32'h00000000};
        ctrl_reg_addr = 4'd6;
        stat_reg_addr = 4'd6;
        dec_wr(4'd6, 32'h0000F00F, 4'hF);
        step();
        dec_wr_en = 1'b0;
        n_tests++;
        if (ctrl_out !== 32'h0000F00F) begin
            n_fail++; $display("FAIL w1c_dec_plain got %h want 0000f00f", ctrl_out);
        end
        for (int k = 0; k < 4; k++) begin
            spi_wr(4'd6, sdat[k], 4'hF);
            stat_hw_set = hset[k];
            step();
            spi_wr_en = 1'b0; stat_hw_set = 32'h0;
            #1;
            n_tests++;
            if (stat_out !== want[k]) begin
                n_fail++; $display("FAIL w1c_step[%0d] got %h want %h", k, stat_out, want[k]);
            end
        end
        dec_wr(4'd7, 32'h12345678, 4'hF);
        step();
        dec_wr_en = 1'b0;
        spi_wr(4'd7, 32'hDEADBEEF, 4'hF);
        #1;
        n_tests++;
        if (spi_wr_ready !== 1'b1) begin
            n_fail++; $display("FAIL ro_ready got %b want 1", spi_wr_ready);
        end
        step();
        spi_wr_en = 1'b0;
        ctrl_reg_addr = 4'd7;
        #1;
        n_tests++;
        if (ctrl_out !== 32'h12345678) begin
            n_fail++; $display("FAIL ro_hold got %h want 12345678", ctrl_out);
        end
    endtask

    task automatic test_rdw();
        dec_wr(4'd1, 32'h5, 4'hF);
        step();
        dec_wr_en = 1'b0;
        spi_wr(4'd1, 32'h9, 4'hF);
        spi_rd_en = 1'b1; spi_addr_rd = 4'd1; dec_addr_rd = 4'd1;
        exp_q.push_back(32'h5);
        step();
        spi_wr_en = 1'b0;
        exp_v = exp_q.pop_front();
        n_tests++;
        if (data_rd_spi !== exp_v || data_rd_dec !== 32'h5) begin
            n_fail++; $display("FAIL rdw_old got %h/%h want %h/5", data_rd_spi, data_rd_dec, exp_v);
        end
        exp_q.push_back(32'h9);
        step();
        exp_v = exp_q.pop_front();
        n_tests++;
        if (data_rd_spi !== exp_v || data_rd_dec !== 32'h9) begin
            n_fail++; $display("FAIL rdw_new got %h/%h want %h/9", data_rd_spi, data_rd_dec, exp_v);
        end
        spi_rd_en = 1'b0; spi_addr_rd = 4'd2;
        step();
        n_tests++;
        if (data_rd_spi !== 32'h9 || spi_rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL rd_hold got %h/%b want 9/0", data_rd_spi, spi_rd_valid);
        end
    endtask

    task automatic test_reset_mid();
        spi_wr(4'd3, 32'hCAFE0001, 4'hF);
        dec_wr(4'd3, 32'hCAFE0002, 4'hF);
        reset_n = 1'b0;
        step();
        idle_inputs();
        reset_n = 1'b1;
        dec_addr_rd = 4'd1;
        #1;
        n_tests++;
        if ({data_rd_spi, data_rd_dec} !== 64'h0 || {spi_rd_valid, wr_collision} !== 2'b00) begin
            n_fail++; $display("FAIL mid_reset_out got %h/%h/%b want 0", data_rd_spi, data_rd_dec, {spi_rd_valid, wr_collision});
        end
        for (int a = 0; a < 16; a++) begin
            ctrl_reg_addr = a[3:0];
            #1;
            n_tests++;
            if (ctrl_out !== 32'h0) begin
                n_fail++; $display("FAIL mid_reset_reg[%0d] got %h want 0", a, ctrl_out);
            end
        end
        model_fav_dec = 1'b0;
        spi_wr(4'd3, 32'hBEEF0001, 4'hF);
        dec_wr(4'd3, 32'hBEEF0002, 4'hF);
        #1;
        n_tests++;
        if ({spi_wr_ready, dec_wr_ready} !== {!model_fav_dec, model_fav_dec}) begin
            n_fail++; $display("FAIL rr_after_reset got %b want %b", {spi_wr_ready, dec_wr_ready}, {!model_fav_dec, model_fav_dec});
        end
        step();
        idle_inputs();
        ctrl_reg_addr = 4'd3;
        #1;
        n_tests++;
        if (ctrl_out !== 32'hBEEF0001) begin
            n_fail++; $display("FAIL reissue_commit got %h want beef0001", ctrl_out);
        end
        step();
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        test_reset();
        test_dual_write();
        test_collision();
        test_strobe();
        test_modes();
        test_rdw();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
